bk_adder_pipe: RTL
==================

Name: bk_adder_pipe

Overview:
- Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor; generalises the fixed 16-bit combinational Brent-Kung adder to WIDTH bits.
- Adds configurable pipeline depth, an add/sub mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits between operand issue and writeback in the math datapath; one operation accepted per cycle when not stalled.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- STAGES, 2, register stages from input to output, 1..3. Any other value is an elaboration error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  operation present on inputs
- ready_o  out  1  block can accept an operation this cycle
- op1_i  in  WIDTH  operand 1
- op2_i  in  WIDTH  operand 2
- carry_i  in  1  carry-in; for subtract it is the inverted borrow-in (1 = no borrow)
- sub_i  in  1  0 = op1+op2+carry_i; 1 = op1+~op2+carry_i
- valid_o  out  1  result present on outputs
- ready_i  in  1  downstream accepts result
- sum_o  out  WIDTH  result
- carry_o  out  1  carry-out of bit WIDTH-1 (for sub: 1 = no borrow)
- ovf_o  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero_o  out  1  sum_o == 0

Behaviour:
- Reset, synchronous, rst_i high at a clock edge:
  - All stage valid bits, valid_o, sum_o, carry_o, ovf_o and zero_o clear to 0.
  - Reset mid-operation discards every in-flight operation; none is emitted afterwards.
  - ready_o = 1 during and after reset.
- Datapath:
  - Pre-processing: b = sub_i ? ~op2_i : op2_i. p = op1^b, g = op1&b, with carry_i folded in as generate at position -1.
  - The Brent-Kung tree (up-sweep, then down-sweep) produces all carries. sum = p ^ carries.
  - All arithmetic is modulo 2^WIDTH; there are no truncation surprises.
- Register placement:
  - STAGES=1: output register only.
  - STAGES=2: adds a register after pre-processing (p, g, cin).
  - STAGES=3: also adds a register after the up-sweep.
  - Latency is exactly STAGES cycles from the accepting edge to valid_o high, when unstalled.
- Handshake:
  - An input transfer occurs on an edge where valid_i && ready_o.
  - An output transfer occurs on an edge where valid_o && ready_i.
  - stall = valid_o && !ready_i; ready_o = !stall. ready_o is combinational from ready_i and valid_o.
  - On stall, every stage register holds and the outputs stay bit-stable.
  - When not stalled, all stages advance. Bubbles advance as valid=0 and are not collapsed.
  - Simultaneous input transfer and output transfer in one cycle is legal, giving full throughput of 1 op per cycle.
  - valid_i low while not stalled inserts a bubble.
  - Inputs are ignored when ready_o is 0.
- Outputs when valid_o = 0: the data outputs hold their last value and are don't-care for checking.
- Ordering: results leave in acceptance order; there is no reordering or drop.

Decomposition:
- Package bk_adder_pkg holds:
  - the log2 helper and tree-level count function LEVELS(WIDTH);
  - localparams for stage-boundary positions;
  - the elaboration checks on WIDTH and STAGES.
- Sub-module carry_tree_bk_param: combinational, parametrised Brent-Kung tree built from existing gray_cell/black_cell. It exposes the up-sweep outputs separately so the STAGES=3 register can be inserted between the sweeps.
- Final sum XOR uses the existing post_processing_param.

Test Plan:
- WIDTH=16, STAGES=2, ready_i=1: op1=0xFFFF, op2=0x0001, carry_i=0, sub_i=0 -> exactly 2 cycles later valid_o=1, sum=0x0000, carry=1, zero=1, ovf=0.
- Signed overflow: 0x7FFF+0x0001, cin=0 -> sum=0x8000, carry=0, ovf=1, zero=0. Subtract 0x8000-0x0001 (sub_i=1, carry_i=1) -> sum=0x7FFF, carry=1, ovf=1.
- Backpressure: issue 4 back-to-back ops (1+1, 2+2, 3+3, 4+4), then hold ready_i=0 for 3 cycles after the first result appears.
  - During the hold: ready_o=0 and sum_o stays stable at 0x0002.
  - After release: results 0x0002, 0x0004, 0x0006, 0x0008 in order, with no duplicates or losses.
- Reset mid-flight: accept 2 ops, assert rst_i for 1 cycle before either emerges -> valid_o stays 0 for the following STAGES+2 cycles and sum_o=0; a new op after reset produces the correct result.
- Throughput and bubbles: valid_i pattern 1,0,1,1 with ready_i=1 -> valid_o pattern 1,0,1,1 delayed by STAGES cycles.
- Sweep: WIDTH=8 with STAGES=1,2,3, all 2^17 combinations of op1/op2/carry_i, both sub_i values, random ready_i -> every result matches the behavioural model (sum, carry, ovf, zero).

Source files
------------

// File: rtl/bk_adder_pkg.sv
// Shared helpers for the pipelined Brent-Kung adder: tree sizing, stage-boundary
// positions, parameter legality checks and the registered flag bundle.
package bk_adder_pkg;

  localparam int unsigned MinWidth  = 8;
  localparam int unsigned MaxWidth  = 64;
  localparam int unsigned MinStages = 1;
  localparam int unsigned MaxStages = 3;

  // A boundary register is present when STAGES is at least its position.
  localparam int unsigned StagePre = 2;
  localparam int unsigned StageUp  = 3;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic int log2_floor(int unsigned v);
    int r;
    r = 0;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 0) r = i;
    end
    return r;
  endfunction

  function automatic int levels(int unsigned width);
    return log2_floor(width);
  endfunction

  function automatic bit width_ok(int unsigned w);
    return (w >= MinWidth) && (w <= MaxWidth) && ((w & (w - 1)) == 0);
  endfunction

  function automatic bit stages_ok(int unsigned s);
    return (s >= MinStages) && (s <= MaxStages);
  endfunction

endpackage

// File: rtl/black_cell.sv
// Prefix black cell: group generate and group propagate.
module black_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

// File: rtl/carry_tree_bk_param.sv
// Parametrised Brent-Kung prefix tree. The up-sweep and down-sweep are exposed as
// separate halves so a pipeline register can sit between them.
module carry_tree_bk_param
  import bk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] up_g_i,
  input  logic [WIDTH-1:0] up_p_i,
  output logic [WIDTH-1:0] up_g_o,
  output logic [WIDTH-1:0] up_p_o,
  input  logic [WIDTH-1:0] dn_g_i,
  input  logic [WIDTH-1:0] dn_p_i,
  output logic [WIDTH-1:0] grp_g_o
);
  localparam int NumLevels = levels(WIDTH);

  logic [NumLevels:0][WIDTH-1:0]   ug;
  logic [NumLevels:0][WIDTH-1:0]   upp;
  logic [NumLevels-1:0][WIDTH-1:0] dg;

  assign ug[0]  = up_g_i;
  assign upp[0] = up_p_i;

  for (genvar l = 0; l < NumLevels; l++) begin : g_up
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_comb
        if (i == (2 ** (l + 1)) - 1) begin : g_gray
          gray_cell u_gray (
            .g_hi_i(ug[l][i]),
            .p_hi_i(upp[l][i]),
            .g_lo_i(ug[l][i-2**l]),
            .g_o   (ug[l+1][i])
          );
          assign upp[l+1][i] = upp[l][i];
        end else begin : g_black
          black_cell u_black (
            .g_hi_i(ug[l][i]),
            .p_hi_i(upp[l][i]),
            .g_lo_i(ug[l][i-2**l]),
            .p_lo_i(upp[l][i-2**l]),
            .g_o   (ug[l+1][i]),
            .p_o   (upp[l+1][i])
          );
        end
      end else begin : g_pass
        assign ug[l+1][i]  = ug[l][i];
        assign upp[l+1][i] = upp[l][i];
      end
    end
  end

  assign up_g_o = ug[NumLevels];
  assign up_p_o = upp[NumLevels];

  // Down-sweep fills the gaps; every combine pairs a node with a finished prefix.
  assign dg[0] = dn_g_i;
  for (genvar s = 0; s < NumLevels - 1; s++) begin : g_dn
    localparam int Lvl = NumLevels - 2 - s;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if ((i >= 2 ** (Lvl + 1)) && (((i + 1) % (2 ** (Lvl + 1))) == 2 ** Lvl)) begin : g_gray
        gray_cell u_gray (
          .g_hi_i(dg[s][i]),
          .p_hi_i(dn_p_i[i]),
          .g_lo_i(dg[s][i-2**Lvl]),
          .g_o   (dg[s+1][i])
        );
      end else begin : g_pass
        assign dg[s+1][i] = dg[s][i];
      end
    end
  end

  assign grp_g_o = dg[NumLevels-1];
endmodule

// File: rtl/gray_cell.sv
// Prefix gray cell: group generate only, used where the span reaches bit 0.
module gray_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  output logic g_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
endmodule

// File: rtl/post_processing_param.sv
// Final sum: per-bit propagate XOR carry-in of that bit.
module post_processing_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o
);
  assign sum_o = p_i ^ c_i;
endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control, carry,
// signed-overflow and zero flags. One to three register stages.
module bk_adder_pipe
  import bk_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o
);
  if (!width_ok(WIDTH) || !stages_ok(STAGES)) begin : g_param_check
    $error("bk_adder_pipe: WIDTH must be a power of two in 8..64, STAGES in 1..3");
  end

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  flags_t           flags_q, flags_d;
  logic             stall;

  assign stall   = valid_q & ~ready_i;
  assign ready_o = rst_i | ~stall;

  // Pre-processing; carry_i enters as a generate below bit 0.
  logic [WIDTH-1:0] b_pre, p_pre, g_pre;
  always_comb begin
    b_pre    = sub_i ? ~op2_i : op2_i;
    p_pre    = op1_i ^ b_pre;
    g_pre    = op1_i & b_pre;
    g_pre[0] = g_pre[0] | (p_pre[0] & carry_i);
  end

  logic             va, cina;
  logic [WIDTH-1:0] pa, ga;

  if (STAGES >= StagePre) begin : g_pre_reg
    logic             v_q, v_d, cin_q, cin_d;
    logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
    always_comb begin
      v_d   = v_q;
      cin_d = cin_q;
      p_d   = p_q;
      g_d   = g_q;
      if (!stall) begin
        v_d   = valid_i;
        cin_d = carry_i;
        p_d   = p_pre;
        g_d   = g_pre;
      end
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) v_q <= 1'b0;
      else       v_q <= v_d;
      cin_q <= cin_d;
      p_q   <= p_d;
      g_q   <= g_d;
    end
    assign va   = v_q;
    assign cina = cin_q;
    assign pa   = p_q;
    assign ga   = g_q;
  end else begin : g_pre_comb
    assign va   = valid_i;
    assign cina = carry_i;
    assign pa   = p_pre;
    assign ga   = g_pre;
  end

  logic [WIDTH-1:0] up_g, up_p, grp_g;
  logic             vb, cinb;
  logic [WIDTH-1:0] pb, ugb, upb;

  if (STAGES >= StageUp) begin : g_up_reg
    logic             v_q, v_d, cin_q, cin_d;
    logic [WIDTH-1:0] p_q, p_d, ug_q, ug_d, up_q, up_d;
    always_comb begin
      v_d   = v_q;
      cin_d = cin_q;
      p_d   = p_q;
      ug_d  = ug_q;
      up_d  = up_q;
      if (!stall) begin
        v_d   = va;
        cin_d = cina;
        p_d   = pa;
        ug_d  = up_g;
        up_d  = up_p;
      end
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) v_q <= 1'b0;
      else       v_q <= v_d;
      cin_q <= cin_d;
      p_q   <= p_d;
      ug_q  <= ug_d;
      up_q  <= up_d;
    end
    assign vb   = v_q;
    assign cinb = cin_q;
    assign pb   = p_q;
    assign ugb  = ug_q;
    assign upb  = up_q;
  end else begin : g_up_comb
    assign vb   = va;
    assign cinb = cina;
    assign pb   = pa;
    assign ugb  = up_g;
    assign upb  = up_p;
  end

  carry_tree_bk_param #(
    .WIDTH(WIDTH)
  ) u_tree (
    .up_g_i (ga),
    .up_p_i (pa),
    .up_g_o (up_g),
    .up_p_o (up_p),
    .dn_g_i (ugb),
    .dn_p_i (upb),
    .grp_g_o(grp_g)
  );

  logic [WIDTH-1:0] carries, sum_nxt;
  flags_t           flags_nxt;

  assign carries = {grp_g[WIDTH-2:0], cinb};

  post_processing_param #(
    .WIDTH(WIDTH)
  ) u_post (
    .p_i  (pb),
    .c_i  (carries),
    .sum_o(sum_nxt)
  );

  always_comb begin
    flags_nxt.carry = grp_g[WIDTH-1];
    flags_nxt.ovf   = grp_g[WIDTH-1] ^ grp_g[WIDTH-2];
    flags_nxt.zero  = (sum_nxt == '0);
  end

  // Data outputs only change when a real result lands, so they hold across bubbles.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    if (!stall) begin
      valid_d = vb;
      if (vb) begin
        sum_d   = sum_nxt;
        flags_d = flags_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = flags_q.carry;
  assign ovf_o   = flags_q.ovf;
  assign zero_o  = flags_q.zero;
endmodule
